// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared state encoding and default frame width for the SIPO deserializer
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sipo_state_e;

endpackage

// File: rtl/sipo_out_stage.sv
// rtl/sipo_out_stage.sv - output word register with valid/ready handshake and overrun pulse
module sipo_out_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_valid_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             word_perr_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             perr_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        overrun_d = 1'b0;
        if (word_valid_i) begin
            // A completing word may replace the pending one only if that one leaves this edge.
            if (!valid_q || out_ready_i) begin
                data_d  = word_i;
                perr_d  = word_perr_i;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign perr_o    = perr_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - MSB-first serial-to-parallel receiver; SIPO_PARITY_EN adds a trailing even-parity bit
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             serial_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    sipo_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;
    logic [WIDTH-1:0] word_data;
    logic             word_done;
    logic             word_perr;

    assign shifted   = {shift_q[WIDTH-2:0], serial_in};
    assign first_bit = {{(WIDTH-1){1'b0}}, serial_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable && frame_start) state_d = SHIFT;
            end
            SHIFT: begin
                if (!enable)                state_d = IDLE;
                else if (frame_start)       state_d = SHIFT;
                else if (cnt_q == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end
            end
            PARITY: begin
                if (enable && frame_start) state_d = SHIFT;
                else                       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        word_perr = 1'b0;
        word_data = shifted;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (enable && frame_start) begin
                    shift_d = first_bit;
                    cnt_d   = CW'(1);
                end else begin
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (!enable) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end else if (frame_start) begin
                    shift_d = first_bit;
                    cnt_d   = CW'(1);
                end else if (cnt_q == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
                    shift_d = shifted;
                    cnt_d   = CW'(WIDTH);
`else
                    word_done = 1'b1;
                    shift_d   = '0;
                    cnt_d     = '0;
`endif
                end else begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                shift_d = '0;
                cnt_d   = '0;
`ifdef SIPO_PARITY_EN
                word_data = shift_q;
                if (enable && frame_start) begin
                    shift_d = first_bit;
                    cnt_d   = CW'(1);
                end else if (enable) begin
                    // Even parity: the XOR over data and parity bit is 0 for a clean word.
                    word_done = 1'b1;
                    word_perr = (^shift_q) ^ serial_in;
                end
`endif
            end
            default: begin
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    sipo_out_stage #(.WIDTH(WIDTH)) u_out_stage (
        .clk          (clk),
        .rst          (reset),
        .word_valid_i (word_done),
        .word_i       (word_data),
        .word_perr_i  (word_perr),
        .out_ready_i  (out_ready),
        .data_o       (parallel_out),
        .valid_o      (out_valid),
        .perr_o       (parity_err),
        .overrun_o    (overrun)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - directed self-checking bench for sipo_deserializer
module tb_sipo_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         frame_start;
    logic         serial_in;
    logic         out_ready;
    logic [W-1:0] parallel_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .frame_start  (frame_start),
        .serial_in    (serial_in),
        .out_ready    (out_ready),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .parity_err   (parity_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame; rdy holds during the frame, rdy_last applies on the completing edge.
    task automatic send_word(input logic [W-1:0] w, input logic p,
                             input logic rdy, input logic rdy_last);
        for (int i = W - 1; i >= 0; i--) begin
            frame_start = (i == W - 1);
            serial_in   = w[i];
`ifdef SIPO_PARITY_EN
            out_ready   = rdy;
`else
            out_ready   = (i == 0) ? rdy_last : rdy;
`endif
            tick();
        end
`ifdef SIPO_PARITY_EN
        frame_start = 1'b0;
        serial_in   = p;
        out_ready   = rdy_last;
        tick();
`endif
        frame_start = 1'b0;
        serial_in   = p;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        frame_start = 1'b0;
        serial_in   = 1'b0;
        out_ready   = 1'b0;
        tick();
        tick();
        check("reset_data",    32'(parallel_out), 32'h0);
        check("reset_valid",   32'(out_valid),    32'h0);
        check("reset_busy",    32'(busy),         32'h0);
        check("reset_overrun", 32'(overrun),      32'h0);
        check("reset_perr",    32'(parity_err),   32'h0);
        reset  = 1'b0;
        enable = 1'b1;

        // 0xA5 with consumer always ready
        send_word(8'hA5, 1'b0, 1'b1, 1'b1);
        check("a5_data",  32'(parallel_out), 32'hA5);
        check("a5_valid", 32'(out_valid),    32'h1);
        check("a5_busy",  32'(busy),         32'h0);
`ifndef SIPO_PARITY_EN
        check("a5_perr",  32'(parity_err),   32'h0);
`endif
        serial_in = 1'b0;
        tick();
        check("a5_accepted", 32'(out_valid), 32'h0);

        // Overrun: 0x3C pending, 0xC3 dropped
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        check("3c_data",    32'(parallel_out), 32'h3C);
        check("3c_valid",   32'(out_valid),    32'h1);
        check("3c_overrun", 32'(overrun),      32'h0);
        send_word(8'hC3, 1'b0, 1'b0, 1'b0);
        check("c3_kept_data", 32'(parallel_out), 32'h3C);
        check("c3_overrun",   32'(overrun),      32'h1);
        check("c3_valid",     32'(out_valid),    32'h1);
        serial_in = 1'b0;
        tick();
        check("overrun_one_cycle", 32'(overrun), 32'h0);

        // Handshake on the completion edge of 0x81
        send_word(8'h81, 1'b0, 1'b0, 1'b1);
        check("81_data",    32'(parallel_out), 32'h81);
        check("81_valid",   32'(out_valid),    32'h1);
        check("81_overrun", 32'(overrun),      32'h0);
        out_ready = 1'b0;
        tick();
        check("81_held", 32'(parallel_out), 32'h81);
        out_ready = 1'b1;
        tick();
        check("81_accepted", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // Restart: frame_start mid-frame discards the prior bits
        frame_start = 1'b1;
        serial_in   = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        check("restart_busy", 32'(busy), 32'h1);
        send_word(8'h96, 1'b0, 1'b0, 1'b0);
        check("restart_data", 32'(parallel_out), 32'h96);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Abort via enable after 4 bits, then 0x5A
        frame_start = 1'b1;
        serial_in   = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("abort_busy",  32'(busy),      32'h0);
        check("abort_valid", 32'(out_valid), 32'h0);
        enable = 1'b1;
        send_word(8'h5A, 1'b0, 1'b0, 1'b0);
        check("5a_data",  32'(parallel_out), 32'h5A);
        check("5a_valid", 32'(out_valid),    32'h1);

        // Asynchronous reset mid-frame with 0x5A still pending
        frame_start = 1'b1;
        serial_in   = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_outputs",
              32'({busy, out_valid, overrun, parity_err, parallel_out}), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        serial_in = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_no_frame", 32'({busy, out_valid}), 32'h0);
        send_word(8'hFF, 1'b0, 1'b1, 1'b1);
        check("ff_data",  32'(parallel_out), 32'hFF);
        check("ff_valid", 32'(out_valid),    32'h1);
        tick();

`ifdef SIPO_PARITY_EN
        send_word(8'h07, 1'b1, 1'b1, 1'b1);
        check("par_good_valid", 32'(out_valid),  32'h1);
        check("par_good_err",   32'(parity_err), 32'h0);
        send_word(8'h07, 1'b0, 1'b1, 1'b1);
        check("par_bad_data", 32'(parallel_out), 32'h07);
        check("par_bad_err",  32'(parity_err),   32'h1);
`else
        send_word(8'h07, 1'b0, 1'b1, 1'b1);
        check("nopar_data", 32'(parallel_out), 32'h07);
        check("nopar_err",  32'(parity_err),   32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
